// File: rtl/aes_tx_pkg.sv
// aes_tx_pkg: shared definitions for the AES block-to-UART byte serializer.
//   state_e      : FSM state encoding (IDLE / HDR / SEND)
//   HDR_BYTE_DEF : default header byte placed ahead of each block
//   clog2()      : ceil(log2(v)), used to size the byte counter
package aes_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_tx_serializer.sv
// aes_tx_serializer: accepts one NUM_BYTES-wide block and feeds it, one byte
// at a time, to a UART transmitter's byte interface, optionally prefixed by a
// header byte.
// Ports:
//   clk, rst              : rising-edge clock, synchronous active-high reset
//   in_data/in_valid      : block offered by the producer
//   in_ready              : high in IDLE; block taken on in_valid & in_ready
//   byte_data/byte_valid  : registered byte offered to the UART
//   byte_require          : UART idle; byte moves on byte_valid & byte_require
//   busy                  : block in progress
//   blk_done              : one-cycle pulse after the last byte of a block
//   blk_cnt               : completed block count (wraps)
module aes_tx_serializer
  import aes_tx_pkg::*;
#(
  parameter int         NUM_BYTES = 16,
  parameter bit         MSB_FIRST = 1'b1,
  parameter bit         HDR_EN    = 1'b0,
  parameter logic [7:0] HDR_BYTE  = HDR_BYTE_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*NUM_BYTES-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [7:0]             byte_data,
  output logic                   byte_valid,
  input  logic                   byte_require,
  output logic                   busy,
  output logic                   blk_done,
  output logic [15:0]            blk_cnt
);

  localparam int DW = 8 * NUM_BYTES;
  localparam int CW = clog2(NUM_BYTES + 1);
  localparam logic [CW-1:0] NB_C = CW'(NUM_BYTES);

  state_e          state_q, state_d;
  logic [DW-1:0]   hold_q, hold_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      bdata_q, bdata_d;
  logic            bvalid_q, bvalid_d;
  logic            done_q, done_d;
  logic [15:0]     blk_cnt_q, blk_cnt_d;
  logic            xfer;

  // Byte at the head of the holding register, in transmit order.
  function automatic logic [7:0] head(input logic [DW-1:0] x);
    return MSB_FIRST ? x[DW-1 -: 8] : x[7:0];
  endfunction

  // Drop the head byte; the holding register only keeps bytes not yet shown.
  function automatic logic [DW-1:0] pop(input logic [DW-1:0] x);
    return MSB_FIRST ? (x << 8) : (x >> 8);
  endfunction

  assign xfer = bvalid_q & byte_require;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    bdata_d   = bdata_q;
    bvalid_d  = bvalid_q;
    done_d    = 1'b0;
    blk_cnt_d = blk_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          cnt_d    = NB_C;
          bvalid_d = 1'b1;
          if (HDR_EN) begin
            state_d = ST_HDR;
            hold_d  = in_data;
            bdata_d = HDR_BYTE;
          end else begin
            state_d = ST_SEND;
            hold_d  = pop(in_data);
            bdata_d = head(in_data);
          end
        end
      end
      ST_HDR: begin
        // Header byte does not count against the data byte counter.
        if (xfer) begin
          state_d = ST_SEND;
          bdata_d = head(hold_q);
          hold_d  = pop(hold_q);
        end
      end
      ST_SEND: begin
        if (xfer) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d   = ST_IDLE;
            bvalid_d  = 1'b0;
            done_d    = 1'b1;
            blk_cnt_d = blk_cnt_q + 16'd1;
          end else begin
            bdata_d = head(hold_q);
            hold_d  = pop(hold_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      cnt_q     <= '0;
      bdata_q   <= 8'h00;
      bvalid_q  <= 1'b0;
      done_q    <= 1'b0;
      blk_cnt_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      bdata_q   <= bdata_d;
      bvalid_q  <= bvalid_d;
      done_q    <= done_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign byte_data  = bdata_q;
  assign byte_valid = bvalid_q;
  assign blk_done   = done_q;
  assign blk_cnt    = blk_cnt_q;

endmodule

// File: tb/tb_aes_tx_serializer.sv
// Bench for aes_tx_serializer. Four instances:
//   0: NUM_BYTES=16, MSB first      1: NUM_BYTES=16, LSB first
//   2: NUM_BYTES=16, header 8'h5A   3: NUM_BYTES=2 (counter wrap)
module tb_aes_tx_serializer;

  logic              clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [127:0]      in_data;
  logic              byte_require;
  logic [3:0]        iv, rdy, bv, bsy, done;
  logic [3:0][7:0]   bd;
  logic [3:0][15:0]  bc;

  aes_tx_serializer #(.NUM_BYTES(16), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(iv[0]), .in_ready(rdy[0]),
    .byte_data(bd[0]), .byte_valid(bv[0]), .byte_require(byte_require),
    .busy(bsy[0]), .blk_done(done[0]), .blk_cnt(bc[0]));

  aes_tx_serializer #(.NUM_BYTES(16), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(iv[1]), .in_ready(rdy[1]),
    .byte_data(bd[1]), .byte_valid(bv[1]), .byte_require(byte_require),
    .busy(bsy[1]), .blk_done(done[1]), .blk_cnt(bc[1]));

  aes_tx_serializer #(.NUM_BYTES(16), .MSB_FIRST(1'b1), .HDR_EN(1'b1), .HDR_BYTE(8'h5A)) dut_c (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(iv[2]), .in_ready(rdy[2]),
    .byte_data(bd[2]), .byte_valid(bv[2]), .byte_require(byte_require),
    .busy(bsy[2]), .blk_done(done[2]), .blk_cnt(bc[2]));

  aes_tx_serializer #(.NUM_BYTES(2), .MSB_FIRST(1'b1)) dut_d (
    .clk(clk), .rst(rst), .in_data(in_data[15:0]), .in_valid(iv[3]), .in_ready(rdy[3]),
    .byte_data(bd[3]), .byte_valid(bv[3]), .byte_require(byte_require),
    .busy(bsy[3]), .blk_done(done[3]), .blk_cnt(bc[3]));

  localparam logic [127:0] D1 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] D2 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

  typedef struct {
    int           s;      // instance
    logic [127:0] d;      // block
    int           n;      // bytes expected
    logic [7:0]   b0;     // first byte on the wire
    int           off;    // index where the arithmetic data run starts
    logic [7:0]   seq0;   // first data byte of the run
    logic [7:0]   step;   // byte-to-byte increment (mod 256)
    int           pulse;  // cycle to pulse in_valid mid-block, -10 = none
  } vec_t;

  int          n_chk = 0;
  int          n_err = 0;
  logic [7:0]  got [0:63];
  int          got_n;
  int          side_err;
  bit          saw_done;
  logic [15:0] exp_cnt [4];
  vec_t        tbl [5];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Offer a block to instance s, hold byte_require low for 'stall' cycles,
  // then record every byte that actually transfers until blk_done shows.
  task automatic xfer_block(input int s, input logic [127:0] d, input int stall, input int pulse_at);
    logic [7:0] first_b;
    @(negedge clk);
    in_data      = d;
    byte_require = (stall == 0);
    iv[s]        = 1'b1;
    @(negedge clk);
    iv[s]    = 1'b0;
    got_n    = 0;
    side_err = 0;
    saw_done = 1'b0;
    first_b  = bd[s];
    for (int c = 0; c < stall + 80 && !saw_done; c++) begin
      if (done[s]) saw_done = 1'b1;
      else begin
        if (!bsy[s] || rdy[s]) side_err++;
        if (c < stall && (!bv[s] || bd[s] !== first_b)) side_err++;
        if (c == pulse_at) begin iv[s] = 1'b1; in_data = ~d; end
        if (c == pulse_at + 2) iv[s] = 1'b0;
        byte_require = (c >= stall);
        if (bv[s] && byte_require && got_n < 64) begin
          got[got_n] = bd[s];
          got_n++;
        end
        @(negedge clk);
      end
    end
    iv[s] = 1'b0;
  endtask

  task automatic check_seq(input string nm, input int n, input logic [7:0] b0,
                           input int off, input logic [7:0] seq0, input logic [7:0] step);
    logic [7:0] e;
    int bad;
    chk({nm, " count"}, got_n, n);
    chk({nm, " first"}, got[0], b0);
    e   = seq0;
    bad = 0;
    for (int i = off; i < n && i < 64; i++) begin
      if (got[i] !== e) bad++;
      e = e + step;
    end
    chk({nm, " seq_bad"}, bad, 0);
    chk({nm, " side_err"}, side_err, 0);
  endtask

  // State at the cycle blk_done is seen, then the pulse must be gone.
  task automatic post(input string nm, input int s);
    chk({nm, " done"}, saw_done, 1);
    chk({nm, " in_ready"}, rdy[s], 1);
    chk({nm, " byte_valid"}, bv[s], 0);
    chk({nm, " busy"}, bsy[s], 0);
    chk({nm, " blk_cnt"}, bc[s], exp_cnt[s]);
    @(negedge clk);
    chk({nm, " done_1cyc"}, done[s], 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int dp;
    tbl[0] = '{0, D1, 16, 8'h00, 0, 8'h00, 8'h11, -10};
    tbl[1] = '{1, D1, 16, 8'hFF, 0, 8'hFF, 8'hEF, -10};
    tbl[2] = '{2, D1, 17, 8'h5A, 1, 8'h00, 8'h11, 5};
    tbl[3] = '{0, D2, 16, 8'h0F, 0, 8'h0F, 8'h0F, -10};
    tbl[4] = '{1, D2, 16, 8'hF0, 0, 8'hF0, 8'hF1, -10};
    for (int s = 0; s < 4; s++) exp_cnt[s] = 16'h0000;

    rst = 1'b1; iv = '0; byte_require = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("rst bv%0d", s), bv[s], 0);
      chk($sformatf("rst bd%0d", s), bd[s], 8'h00);
      chk($sformatf("rst rdy%0d", s), rdy[s], 1);
      chk($sformatf("rst busy%0d", s), bsy[s], 0);
      chk($sformatf("rst done%0d", s), done[s], 0);
      chk($sformatf("rst cnt%0d", s), bc[s], 16'h0000);
    end
    rst = 1'b0;

    // Back-to-back blocks, byte_require tied high.
    for (int i = 0; i < 5; i++) begin
      xfer_block(tbl[i].s, tbl[i].d, 0, tbl[i].pulse);
      exp_cnt[tbl[i].s] = exp_cnt[tbl[i].s] + 16'd1;
      check_seq($sformatf("vec%0d", i), tbl[i].n, tbl[i].b0, tbl[i].off, tbl[i].seq0, tbl[i].step);
      post($sformatf("vec%0d", i), tbl[i].s);
    end

    // Downstream stalled 50 cycles right after acceptance.
    xfer_block(0, D1, 50, -10);
    exp_cnt[0] = exp_cnt[0] + 16'd1;
    check_seq("stall", 16, 8'h00, 0, 8'h00, 8'h11);
    post("stall", 0);

    // Reset after 5 bytes have gone out.
    @(negedge clk);
    in_data = D1; byte_require = 1'b1; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst pre bv", bv[0], 1);
    chk("midrst pre bd", bd[0], 8'h55);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 4; s++) exp_cnt[s] = 16'h0000;
    chk("midrst bv", bv[0], 0);
    chk("midrst rdy", rdy[0], 1);
    chk("midrst busy", bsy[0], 0);
    chk("midrst cnt", bc[0], 16'h0000);
    dp = 0;
    for (int c = 0; c < 4; c++) begin
      if (done[0]) dp++;
      @(negedge clk);
    end
    chk("midrst no_done", dp, 0);
    xfer_block(0, D1, 0, -10);
    exp_cnt[0] = exp_cnt[0] + 16'd1;
    check_seq("afterrst", 16, 8'h00, 0, 8'h00, 8'h11);
    post("afterrst", 0);

    // blk_cnt wrap on the 2-byte instance.
    @(negedge clk);
    force dut_d.blk_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut_d.blk_cnt_q;
    @(negedge clk);
    exp_cnt[3] = 16'hFFFF;
    chk("wrap preset", bc[3], 16'hFFFF);
    xfer_block(3, 128'hBEEF, 0, -10);
    exp_cnt[3] = exp_cnt[3] + 16'd1;
    chk("wrap count", got_n, 2);
    chk("wrap b0", got[0], 8'hBE);
    chk("wrap b1", got[1], 8'hEF);
    chk("wrap side_err", side_err, 0);
    post("wrap", 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
